// File: rtl/dvs_fifo_pkg.sv
// Shared constants and helpers for the event FIFO: read-mode encodings,
// default flag thresholds and the count-width calculation.
package dvs_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    localparam int DEFAULT_AE_LEVEL  = 4;
    localparam int DEFAULT_AF_MARGIN = 8;

    typedef enum logic {
        READ_STD  = 1'b0,
        READ_FWFT = 1'b1
    } read_mode_e;

    // One extra bit so a completely full FIFO (count == DEPTH) is representable.
    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_bram_sdp.sv
// Simple dual-port RAM with registered read, written to infer iCE40 block RAM.
// The array is never reset; only the read output register is.
module fifo_bram_sdp #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wrEn,
    input  logic [AW-1:0] i_wrAddr,
    input  logic [DW-1:0] i_wrData,
    input  logic          i_rdEn,
    input  logic [AW-1:0] i_rdAddr,
    output logic [DW-1:0] o_rdData
);

    localparam int WORDS = 1 << AW;

    logic [DW-1:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Output register holds its value whenever no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rdData <= '0;
        end else if (i_rdEn) begin
            o_rdData <= r_mem[i_rdAddr];
        end
    end

endmodule

// File: rtl/event_fifo_fwft.sv
// Event FIFO with first-word-fall-through or registered-read output and
// registered status flags. Define EVENT_FIFO_STATS_EN to add drop_count/high_water.
module event_fifo_fwft
    import dvs_fifo_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 32,
    parameter int FWFT       = FIFO_MODE_FWFT,
    parameter int AF_LEVEL   = DEPTH - DEFAULT_AF_MARGIN,
    parameter int AE_LEVEL   = DEFAULT_AE_LEVEL
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [countWidth(DEPTH)-1:0]  count,
    output logic                          overflow
`ifdef EVENT_FIFO_STATS_EN
    ,
    output logic [15:0]                   drop_count,
    output logic [countWidth(DEPTH)-1:0]  high_water
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = countWidth(DEPTH);

    localparam logic [CW-1:0] AF_TH    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_TH    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW:0]           r_wrPtr;
    logic [AW:0]           r_rdPtr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almostFull;
    logic                  r_almostEmpty;
    logic                  r_overflow;

    logic                  w_wrAcc;
    logic                  w_wrDrop;
    logic                  w_pop;
    logic                  w_ramRd;
    logic [DATA_WIDTH-1:0] w_ramData;
    logic [CW-1:0]         w_countNext;

    assign w_wrAcc  = wr_en & ~r_full;
    assign w_wrDrop = wr_en & r_full;

    fifo_bram_sdp #(
        .AW (AW),
        .DW (DATA_WIDTH)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .i_wrEn   (w_wrAcc),
        .i_wrAddr (r_wrPtr[AW-1:0]),
        .i_wrData (wr_data),
        .i_rdEn   (w_ramRd),
        .i_rdAddr (r_rdPtr[AW-1:0]),
        .o_rdData (w_ramData)
    );

    // Pointers carry one extra wrap bit and roll over modulo 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_wrAcc) begin
                r_wrPtr <= r_wrPtr + (AW+1)'(1);
            end
            if (w_ramRd) begin
                r_rdPtr <= r_rdPtr + (AW+1)'(1);
            end
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // RAM output acts as a staging slot feeding the visible output register,
            // giving two-cycle fall-through latency and one pop per cycle.
            logic                  r_stageValid;
            logic                  r_outValid;
            logic [DATA_WIDTH-1:0] r_outData;
            logic                  w_outLoad;

            assign w_pop     = rd_en & r_outValid;
            assign w_outLoad = r_stageValid & (~r_outValid | w_pop);
            assign w_ramRd   = (r_rdPtr != r_wrPtr) & (~r_stageValid | w_outLoad);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_stageValid <= 1'b0;
                    r_outValid   <= 1'b0;
                    r_outData    <= '0;
                end else begin
                    if (w_ramRd) begin
                        r_stageValid <= 1'b1;
                    end else if (w_outLoad) begin
                        r_stageValid <= 1'b0;
                    end
                    if (w_outLoad) begin
                        r_outValid <= 1'b1;
                        r_outData  <= w_ramData;
                    end else if (w_pop) begin
                        r_outValid <= 1'b0;
                    end
                end
            end

            assign rd_valid = r_outValid;
            assign rd_data  = r_outData;
        end else begin : g_std
            logic r_rdValid;

            assign w_pop   = rd_en & ~r_empty;
            assign w_ramRd = w_pop;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rdValid <= 1'b0;
                end else begin
                    r_rdValid <= w_pop;
                end
            end

            assign rd_valid = r_rdValid;
            assign rd_data  = w_ramData;
        end
    endgenerate

    always_comb begin
        w_countNext = r_count;
        if (w_wrAcc && !w_pop) begin
            w_countNext = r_count + CW'(1);
        end else if (!w_wrAcc && w_pop) begin
            w_countNext = r_count - CW'(1);
        end
    end

    // All flags derive from the next count so they stay consistent with count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almostFull  <= 1'b0;
            r_almostEmpty <= 1'b1;
            r_overflow    <= 1'b0;
        end else begin
            r_count       <= w_countNext;
            r_full        <= (w_countNext == FULL_CNT);
            r_empty       <= (w_countNext == '0);
            r_almostFull  <= (w_countNext >= AF_TH);
            r_almostEmpty <= (w_countNext <= AE_TH);
            r_overflow    <= w_wrDrop;
        end
    end

    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almostFull;
    assign almost_empty = r_almostEmpty;
    assign overflow     = r_overflow;

`ifdef EVENT_FIFO_STATS_EN
    logic [15:0]   r_dropCount;
    logic [CW-1:0] r_highWater;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dropCount <= '0;
            r_highWater <= '0;
        end else begin
            if (w_wrDrop && (r_dropCount != 16'hFFFF)) begin
                r_dropCount <= r_dropCount + 16'd1;
            end
            if (w_countNext > r_highWater) begin
                r_highWater <= w_countNext;
            end
        end
    end

    assign drop_count = r_dropCount;
    assign high_water = r_highWater;
`endif

endmodule

// File: tb/tb_event_fifo_fwft.sv
// Scoreboard bench: one FWFT and one registered-read instance share stimulus;
// queue-based reference models predict at each edge, a monitor compares mid-cycle.
module tb_event_fifo_fwft;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic [DW-1:0] rdDataF, rdDataS;
    logic          rdValidF, rdValidS;
    logic          fullF, fullS, emptyF, emptyS;
    logic          afF, afS, aeF, aeS;
    logic [CW-1:0] countF, countS;
    logic          ovfF, ovfS;
`ifdef EVENT_FIFO_STATS_EN
    logic [15:0]   dropCountF, dropCountS;
    logic [CW-1:0] highWaterF, highWaterS;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] qF[$];
    logic [DW-1:0] qS[$];
    logic          expOvfF   = 1'b0;
    logic          expOvfS   = 1'b0;
    logic          pendS     = 1'b0;
    logic [DW-1:0] pendWordS = '0;
    logic [DW-1:0] lastRdS   = '0;
    int            dropF     = 0;
    int            hwF       = 0;

    always #5 clk = ~clk;

    event_fifo_fwft #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(4)
    ) dutF (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rdDataF), .rd_valid(rdValidF), .full(fullF), .empty(emptyF),
        .almost_full(afF), .almost_empty(aeF), .count(countF), .overflow(ovfF)
`ifdef EVENT_FIFO_STATS_EN
        , .drop_count(dropCountF), .high_water(highWaterF)
`endif
    );

    event_fifo_fwft #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(4)
    ) dutS (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rdDataS), .rd_valid(rdValidS), .full(fullS), .empty(emptyS),
        .almost_full(afS), .almost_empty(aeS), .count(countS), .overflow(ovfS)
`ifdef EVENT_FIFO_STATS_EN
        , .drop_count(dropCountS), .high_water(highWaterS)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle of stimulus: inputs are held across the next rising edge.
    task automatic applyStimulus(input logic w, input logic [DW-1:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCheck();
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("validF_idle", 32'(rdValidF), 32'(qF.size() > 0));
    endtask

    task automatic drain();
        repeat (24) applyStimulus(1'b0, 8'h00, 1'b1);
        idleCheck();
    endtask

    // Reference models advance on each edge from the FIFO rules alone.
    always @(posedge clk) begin
        bit fullNowF;
        bit fullNowS;
        if (!rst) begin
            fullNowF = (qF.size() == DEPTH);
            fullNowS = (qS.size() == DEPTH);
            expOvfF  = wr_en && fullNowF;
            expOvfS  = wr_en && fullNowS;
            if (wr_en && fullNowF && dropF < 65535) dropF++;
            if (rd_en && rdValidF && qF.size() > 0) void'(qF.pop_front());
            if (wr_en && !fullNowF) qF.push_back(wr_data);
            pendS = rd_en && (qS.size() > 0);
            if (pendS) pendWordS = qS.pop_front();
            if (wr_en && !fullNowS) qS.push_back(wr_data);
        end
    end

    // Monitor: compare both instances against the models away from the clock edge.
    always @(negedge clk) begin
        if (rst) begin
            qF.delete();
            qS.delete();
            expOvfF = 1'b0;
            expOvfS = 1'b0;
            pendS   = 1'b0;
            lastRdS = '0;
            dropF   = 0;
            hwF     = 0;
        end else begin
            if (qF.size() > hwF) hwF = qF.size();
            checkOutput("countF", 32'(countF), 32'(qF.size()));
            checkOutput("fullF",  32'(fullF),  32'(qF.size() == DEPTH));
            checkOutput("emptyF", 32'(emptyF), 32'(qF.size() == 0));
            checkOutput("afF",    32'(afF),    32'(qF.size() >= 12));
            checkOutput("aeF",    32'(aeF),    32'(qF.size() <= 4));
            checkOutput("ovfF",   32'(ovfF),   32'(expOvfF));
            if (qF.size() == 0) checkOutput("validF_empty", 32'(rdValidF), 32'(0));
            else if (rdValidF)  checkOutput("headF", 32'(rdDataF), 32'(qF[0]));

            checkOutput("countS", 32'(countS), 32'(qS.size()));
            checkOutput("fullS",  32'(fullS),  32'(qS.size() == DEPTH));
            checkOutput("emptyS", 32'(emptyS), 32'(qS.size() == 0));
            checkOutput("afS",    32'(afS),    32'(qS.size() >= 12));
            checkOutput("aeS",    32'(aeS),    32'(qS.size() <= 4));
            checkOutput("ovfS",   32'(ovfS),   32'(expOvfS));
            checkOutput("validS", 32'(rdValidS), 32'(pendS));
            if (pendS) begin
                checkOutput("dataS", 32'(rdDataS), 32'(pendWordS));
                lastRdS = pendWordS;
            end else begin
                checkOutput("holdS", 32'(rdDataS), 32'(lastRdS));
            end
`ifdef EVENT_FIFO_STATS_EN
            checkOutput("dropCountF", 32'(dropCountF), 32'(dropF));
            checkOutput("highWaterF", 32'(highWaterF), 32'(hwF));
`endif
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_countF", 32'(countF),   32'(0));
        checkOutput("rst_emptyF", 32'(emptyF),   32'(1));
        checkOutput("rst_aeF",    32'(aeF),      32'(1));
        checkOutput("rst_validF", 32'(rdValidF), 32'(0));
        checkOutput("rst_validS", 32'(rdValidS), 32'(0));
        #2 rst = 1'b0;

        // Fall-through latency of a single word into an empty FIFO.
        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput("lat_countF", 32'(countF),   32'(1));
        checkOutput("lat0_validF", 32'(rdValidF), 32'(0));
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("lat1_validF", 32'(rdValidF), 32'(0));
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("lat2_validF", 32'(rdValidF), 32'(1));
        checkOutput("lat2_dataF",  32'(rdDataF),  32'(8'hA5));
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Fill past capacity; the 17th write must be dropped.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i + 8'h10), 1'b0);
        checkOutput("fill_fullF", 32'(fullF), 32'(1));
        applyStimulus(1'b1, 8'hEE, 1'b0);
        checkOutput("fill_ovfF", 32'(ovfF), 32'(1));
        idleCheck();

        // Simultaneous read and write starting from full, then drain.
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'($urandom_range(0, 255)), 1'b1);
        drain();

        // Step the count up and down to walk both thresholds.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
            repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
        end
        idleCheck();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 9) < 6), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 9) < 5));
        end
        idleCheck();
        drain();

        // Registered-read instance: three words, four read pulses.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            applyStimulus(1'b0, 8'h00, 1'b0);
            checkOutput("std_countS", 32'(countS), 32'((i < 3) ? (2 - i) : 0));
        end
        idleCheck();

        // Asynchronous reset in the middle of a stream holding nine words.
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        checkOutput("pre_rst_countF", 32'(countF), 32'(9));
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'h77;
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_countF", 32'(countF),   32'(0));
        checkOutput("arst_emptyF", 32'(emptyF),   32'(1));
        checkOutput("arst_aeF",    32'(aeF),      32'(1));
        checkOutput("arst_fullF",  32'(fullF),    32'(0));
        checkOutput("arst_validF", 32'(rdValidF), 32'(0));
        checkOutput("arst_dataF",  32'(rdDataF),  32'(0));
        checkOutput("arst_countS", 32'(countS),   32'(0));
        checkOutput("arst_dataS",  32'(rdDataS),  32'(0));
        wr_data = 8'h3C;
        rd_en   = 1'b0;
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_countF", 32'(countF), 32'(1));
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("post_rst_dataF", 32'(rdDataF), 32'(8'h3C));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
